pca_reg_sequencer: RTL and testbench

PCA_REG_SEQUENCER -- requirements
Module: pca_reg_sequencer

---
 rtl/pca_pkg.sv | 34 +++
 rtl/pca_reg_defaults.sv | 33 +++
 rtl/pca_reg_sequencer.sv | 135 +++++++++++++
 tb/tb_pca_reg_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pca_pkg.sv
// Shared definitions for the PCA register sequencer: register ids, their
// power-on default values and the sequencer state encoding.
package pca_pkg;

  localparam logic [7:0] MODE1         = 8'h00;
  localparam logic [7:0] MODE2         = 8'h01;
  localparam logic [7:0] SUBADR1       = 8'h02;
  localparam logic [7:0] SUBADR2       = 8'h03;
  localparam logic [7:0] SUBADR3       = 8'h04;
  localparam logic [7:0] ALLCALLADR    = 8'h05;
  localparam logic [7:0] LED0_ON_L     = 8'h06;
  localparam logic [7:0] LED15_OFF_H   = 8'h45;
  localparam logic [7:0] ALL_LED_OFF_H = 8'hFD;
  localparam logic [7:0] PRE_SCALE     = 8'hFE;

  localparam logic [7:0] MODE1_DEFAULT         = 8'h11;
  localparam logic [7:0] MODE2_DEFAULT         = 8'h04;
  localparam logic [7:0] SUBADR1_DEFAULT       = 8'hE2;
  localparam logic [7:0] SUBADR2_DEFAULT       = 8'hE4;
  localparam logic [7:0] SUBADR3_DEFAULT       = 8'hE8;
  localparam logic [7:0] ALLCALLADR_DEFAULT    = 8'hE0;
  localparam logic [7:0] LED_OFF_H_DEFAULT     = 8'h10;
  localparam logic [7:0] ALL_LED_OFF_H_DEFAULT = 8'h10;
  localparam logic [7:0] PRE_SCALE_DEFAULT     = 8'h1E;

  // Each LED channel occupies four ids; the fourth (OFF_H) holds the full-off bit.
  localparam logic [1:0] LED_OFF_H_SLOT = 2'd3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pca_reg_defaults.sv
// Combinational power-on default lookup for every register id.
module pca_reg_defaults
  import pca_pkg::*;
(
  input  logic [7:0] id_i,
  output logic [7:0] value_o
);

  logic [7:0] led_offset;

  assign led_offset = id_i - LED0_ON_L;

  always_comb begin
    value_o = 8'h00;
    case (id_i)
      MODE1:         value_o = MODE1_DEFAULT;
      MODE2:         value_o = MODE2_DEFAULT;
      SUBADR1:       value_o = SUBADR1_DEFAULT;
      SUBADR2:       value_o = SUBADR2_DEFAULT;
      SUBADR3:       value_o = SUBADR3_DEFAULT;
      ALLCALLADR:    value_o = ALLCALLADR_DEFAULT;
      ALL_LED_OFF_H: value_o = ALL_LED_OFF_H_DEFAULT;
      PRE_SCALE:     value_o = PRE_SCALE_DEFAULT;
      default: begin
        if ((id_i >= LED0_ON_L) && (id_i <= LED15_OFF_H) &&
            (led_offset[1:0] == LED_OFF_H_SLOT)) begin
          value_o = LED_OFF_H_DEFAULT;
        end
      end
    endcase
  end

endmodule

// File: rtl/pca_reg_sequencer.sv
// Loads register defaults after reset, then arbitrates I2C target writes
// (edge-captured, highest priority) and internal requester writes.
module pca_reg_sequencer
  import pca_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       soft_rst_ni,
  input  logic       i2c_we_i,
  input  logic [7:0] i2c_id_i,
  input  logic [7:0] i2c_value_i,
  input  logic       int_req_i,
  input  logic [7:0] int_id_i,
  input  logic [7:0] int_value_i,
  output logic       int_ack_o,
  output logic       reg_we_o,
  output logic [7:0] reg_id_o,
  output logic [7:0] reg_value_o,
  output logic       init_done_o,
  output logic       drop_o
);

  seq_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       i2c_we_prev_q;
  logic       i2c_edge;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] pend_id_q, pend_id_d;
  logic [7:0] pend_value_q, pend_value_d;
  logic       reg_we_d;
  logic [7:0] reg_id_d, reg_value_d;
  logic       int_ack_d, drop_d, init_done_d;
  logic [7:0] default_value;

  pca_reg_defaults u_defaults (
    .id_i    (cnt_q),
    .value_o (default_value)
  );

  // The previous-level register resets high so a level already high at reset release is not an edge.
  assign i2c_edge = i2c_we_i & ~i2c_we_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_INIT;
      cnt_q         <= 8'h00;
      i2c_we_prev_q <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_id_q     <= 8'h00;
      pend_value_q  <= 8'h00;
      reg_we_o      <= 1'b0;
      reg_id_o      <= 8'h00;
      reg_value_o   <= 8'h00;
      int_ack_o     <= 1'b0;
      drop_o        <= 1'b0;
      init_done_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      i2c_we_prev_q <= i2c_we_i;
      pend_valid_q  <= pend_valid_d;
      pend_id_q     <= pend_id_d;
      pend_value_q  <= pend_value_d;
      reg_we_o      <= reg_we_d;
      reg_id_o      <= reg_id_d;
      reg_value_o   <= reg_value_d;
      int_ack_o     <= int_ack_d;
      drop_o        <= drop_d;
      init_done_o   <= init_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_id_d    = pend_id_q;
    pend_value_d = pend_value_q;
    reg_we_d     = 1'b0;
    reg_id_d     = reg_id_o;
    reg_value_d  = reg_value_o;
    int_ack_d    = 1'b0;
    drop_d       = 1'b0;
    init_done_d  = (state_q == ST_RUN);

    if (!soft_rst_ni) begin
      state_d      = ST_INIT;
      cnt_d        = 8'h00;
      pend_valid_d = 1'b0;
      init_done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          reg_we_d    = 1'b1;
          reg_id_d    = cnt_q;
          reg_value_d = default_value;
          drop_d      = i2c_edge;
          if (cnt_q == 8'hFF) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RUN: begin
          // A parked I2C write goes first; a new edge behind it takes the slot.
          if (pend_valid_q) begin
            reg_we_d     = 1'b1;
            reg_id_d     = pend_id_q;
            reg_value_d  = pend_value_q;
            pend_valid_d = i2c_edge;
            if (i2c_edge) begin
              pend_id_d    = i2c_id_i;
              pend_value_d = i2c_value_i;
            end
          end else if (i2c_edge) begin
            reg_we_d    = 1'b1;
            reg_id_d    = i2c_id_i;
            reg_value_d = i2c_value_i;
          end else if (int_req_i && !int_ack_o) begin
            // A request still high during its own ack cycle was already served.
            reg_we_d    = 1'b1;
            reg_id_d    = int_id_i;
            reg_value_d = int_value_i;
            int_ack_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pca_reg_sequencer.sv
// Directed self-checking bench for pca_reg_sequencer.
module tb_pca_reg_sequencer;

  logic       clk_i;
  logic       rst_i;
  logic       soft_rst_ni;
  logic       i2c_we_i;
  logic [7:0] i2c_id_i;
  logic [7:0] i2c_value_i;
  logic       int_req_i;
  logic [7:0] int_id_i;
  logic [7:0] int_value_i;
  logic       int_ack_o;
  logic       reg_we_o;
  logic [7:0] reg_id_o;
  logic [7:0] reg_value_o;
  logic       init_done_o;
  logic       drop_o;

  int n_vec;
  int n_fail;

  pca_reg_sequencer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .soft_rst_ni (soft_rst_ni),
    .i2c_we_i    (i2c_we_i),
    .i2c_id_i    (i2c_id_i),
    .i2c_value_i (i2c_value_i),
    .int_req_i   (int_req_i),
    .int_id_i    (int_id_i),
    .int_value_i (int_value_i),
    .int_ack_o   (int_ack_o),
    .reg_we_o    (reg_we_o),
    .reg_id_o    (reg_id_o),
    .reg_value_o (reg_value_o),
    .init_done_o (init_done_o),
    .drop_o      (drop_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hand-written default table, independent of the design's lookup.
  function automatic logic [7:0] exp_default(input int id);
    case (id)
      0:   return 8'h11;
      1:   return 8'h04;
      2:   return 8'hE2;
      3:   return 8'hE4;
      4:   return 8'hE8;
      5:   return 8'hE0;
      253: return 8'h10;
      254: return 8'h1E;
      default: begin
        if (id >= 6 && id <= 69 && ((id - 6) % 4) == 3) return 8'h10;
        return 8'h00;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Observed bundle: {we, id, value, ack, drop, done}
  task automatic test_reset();
    logic [19:0] obs;
    rst_i = 1'b1;
    tick();
    tick();
    obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o, drop_o, init_done_o};
    n_vec++;
    if (obs !== 20'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state got=%h want=%h", obs, 20'h0);
    end
  endtask

  task automatic test_init_load();
    logic [19:0] obs, exp;
    rst_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o, drop_o, init_done_o};
      exp = {1'b1, 8'(i), exp_default(i), 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL init_write[%0d] got=%h want=%h", i, obs, exp);
      end
    end
    tick();
    n_vec++;
    if ({reg_we_o, init_done_o} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL init_done_rise got we,done=%b%b want=01", reg_we_o, init_done_o);
    end
  endtask

  task automatic test_held_level();
    logic [16:0] obs;
    i2c_we_i    = 1'b1;
    i2c_id_i    = 8'hFE;
    i2c_value_i = 8'h79;
    for (int c = 0; c < 10; c++) begin
      tick();
      obs = {reg_we_o, reg_id_o, reg_value_o};
      n_vec++;
      if (obs !== {(c == 0), 8'hFE, 8'h79}) begin
        n_fail++;
        $display("[TB] FAIL held_level[%0d] got=%h want=%h", c, obs, {(c == 0), 8'hFE, 8'h79});
      end
    end
    i2c_we_i = 1'b0;
    tick();
    n_vec++;
    if ({reg_we_o, int_ack_o, drop_o} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL held_level_release got=%b want=000", {reg_we_o, int_ack_o, drop_o});
    end
  endtask

  task automatic test_collision();
    logic [17:0] obs;
    i2c_we_i    = 1'b1;
    i2c_id_i    = 8'h06;
    i2c_value_i = 8'h55;
    int_req_i   = 1'b1;
    int_id_i    = 8'h07;
    int_value_i = 8'hAA;
    tick();
    obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o};
    n_vec++;
    if (obs !== {1'b1, 8'h06, 8'h55, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL collision_i2c got=%h want=%h", obs, {1'b1, 8'h06, 8'h55, 1'b0});
    end
    tick();
    obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o};
    n_vec++;
    if (obs !== {1'b1, 8'h07, 8'hAA, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL collision_int got=%h want=%h", obs, {1'b1, 8'h07, 8'hAA, 1'b1});
    end
    int_req_i = 1'b0;
    tick();
    obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o};
    n_vec++;
    if (obs !== {1'b0, 8'h07, 8'hAA, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL collision_idle got=%h want=%h", obs, {1'b0, 8'h07, 8'hAA, 1'b0});
    end
    i2c_we_i = 1'b0;
    tick();
  endtask

  // Soft reset from RUN, I2C drop at id 0x10, soft reset again at id 0x80,
  // internal request held throughout INIT and acked on the first RUN cycle.
  task automatic test_soft_reset_mid_init();
    logic [19:0] obs, exp;
    soft_rst_ni = 1'b0;
    tick();
    n_vec++;
    if ({reg_we_o, init_done_o} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL soft_rst_run got we,done=%b%b want=00", reg_we_o, init_done_o);
    end
    soft_rst_ni = 1'b1;
    int_req_i   = 1'b1;
    int_id_i    = 8'h33;
    int_value_i = 8'h44;
    i2c_id_i    = 8'h99;
    i2c_value_i = 8'h5A;
    for (int i = 0; i <= 8'h80; i++) begin
      tick();
      obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o, drop_o, init_done_o};
      exp = {1'b1, 8'(i), exp_default(i), 1'b0, (i == 8'h11), 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL reload1[%0d] got=%h want=%h", i, obs, exp);
      end
      if (i == 8'h10) i2c_we_i = 1'b1;
      if (i == 8'h14) i2c_we_i = 1'b0;
    end
    soft_rst_ni = 1'b0;
    tick();
    n_vec++;
    if ({reg_we_o, int_ack_o, init_done_o} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL soft_rst_init got=%b want=000", {reg_we_o, int_ack_o, init_done_o});
    end
    soft_rst_ni = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o, drop_o, init_done_o};
      exp = {1'b1, 8'(i), exp_default(i), 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL reload2[%0d] got=%h want=%h", i, obs, exp);
      end
    end
    tick();
    obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o, drop_o, init_done_o};
    exp = {1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL first_run_ack got=%h want=%h", obs, exp);
    end
    int_req_i = 1'b0;
    tick();
    n_vec++;
    if ({reg_we_o, int_ack_o} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL ack_single got we,ack=%b%b want=00", reg_we_o, int_ack_o);
    end
  endtask

  // A write level already high when reset releases must never be captured.
  task automatic test_release_with_we_high();
    logic [19:0] obs, exp;
    i2c_we_i    = 1'b1;
    i2c_id_i    = 8'h22;
    i2c_value_i = 8'h77;
    rst_i       = 1'b1;
    tick();
    n_vec++;
    if ({reg_we_o, reg_id_o, reg_value_o, init_done_o} !== 18'h0) begin
      n_fail++;
      $display("[TB] FAIL rereset_state got=%h want=0", {reg_we_o, reg_id_o, reg_value_o, init_done_o});
    end
    rst_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      obs = {reg_we_o, reg_id_o, reg_value_o, int_ack_o, drop_o, init_done_o};
      exp = {1'b1, 8'(i), exp_default(i), 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL held_release_init[%0d] got=%h want=%h", i, obs, exp);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if ({reg_we_o, init_done_o} !== 2'b01) begin
        n_fail++;
        $display("[TB] FAIL held_release_run[%0d] got we,done=%b%b want=01", c, reg_we_o, init_done_o);
      end
    end
    i2c_we_i = 1'b0;
    tick();
  endtask

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    rst_i       = 1'b1;
    soft_rst_ni = 1'b1;
    i2c_we_i    = 1'b0;
    i2c_id_i    = 8'h00;
    i2c_value_i = 8'h00;
    int_req_i   = 1'b0;
    int_id_i    = 8'h00;
    int_value_i = 8'h00;
    test_reset();
    test_init_load();
    test_held_level();
    test_collision();
    test_soft_reset_mid_init();
    test_release_with_we_high();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
